// File: rtl/sign_mag_defs.sv
// Shared definitions for the sign-magnitude normalizer and the pack stage.
package sign_mag_defs;

  // Normalizer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default exponent width and its saturated (all-ones) value.
  localparam int              EXP_W_DEF = 8;
  localparam logic [EXP_W_DEF-1:0] EXP_MAX = '1;

endpackage

// File: rtl/twos_to_signmag.sv
// Converts the complement adder's raw sum/carry back to sign-magnitude.
module twos_to_signmag #(
  parameter int WIDTH = 23
) (
  input  logic             i_sign1,
  input  logic             i_sign2,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_carry,
  output logic             o_sign,
  output logic [WIDTH:0]   o_mag
);

  // Equal signs: true add, carry is the magnitude MSB. Differing signs: no
  // carry means the result went negative, so re-complement the sum.
  always_comb begin
    o_sign = 1'b0;
    o_mag  = '0;
    if (i_sign1 == i_sign2) begin
      o_sign = i_sign1;
      o_mag  = {i_carry, i_sum};
    end else if (i_carry) begin
      o_sign = 1'b0;
      o_mag  = {1'b0, i_sum};
    end else begin
      o_sign = 1'b1;
      o_mag  = {1'b0, (~i_sum) + WIDTH'(1)};
    end
    // A zero result is always reported positive.
    if (o_mag == '0) o_sign = 1'b0;
  end

endmodule

// File: rtl/sign_mag_normalizer.sv
// Sign-magnitude conversion plus iterative one-bit-per-cycle normalization.
module sign_mag_normalizer
  import sign_mag_defs::*;
#(
  parameter int WIDTH     = 23,
  parameter int EXP_WIDTH = EXP_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_sign1,
  input  logic                 i_sign2,
  input  logic [WIDTH-1:0]     i_sum,
  input  logic                 i_carry,
  input  logic [EXP_WIDTH-1:0] i_exp,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_sign,
  output logic [WIDTH-1:0]     o_mant,
  output logic [EXP_WIDTH-1:0] o_exp,
  output logic                 o_zero,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;

  state_e               state_q, state_d;
  logic [WIDTH:0]       m_q, m_d;
  logic                 sign_q, sign_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic                 zero_q, zero_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  logic                 dec_sign;
  logic [WIDTH:0]       dec_mag;
  logic [EXP_WIDTH-1:0] exp_inc;

  twos_to_signmag #(.WIDTH(WIDTH)) u_dec (
    .i_sign1 (i_sign1),
    .i_sign2 (i_sign2),
    .i_sum   (i_sum),
    .i_carry (i_carry),
    .o_sign  (dec_sign),
    .o_mag   (dec_mag)
  );

  assign exp_inc = exp_q + EXP_WIDTH'(1);

  // Next-state: load in IDLE, one normalization step per cycle in NORM,
  // hold everything in DONE until the downstream takes it.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          m_d     = dec_mag;
          sign_d  = dec_sign;
          exp_d   = i_exp;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = NORM;
        end
      end
      NORM: begin
        if (m_q == '0) begin
          zero_d  = 1'b1;
          exp_d   = '0;
          state_d = DONE;
        end else if (m_q[WIDTH]) begin
          // Carry into the hidden position: one right shift, LSB dropped.
          m_d   = m_q >> 1;
          exp_d = exp_inc;
          if (exp_inc == EXP_ONES) begin
            ovf_d = 1'b1;
            m_d   = '0;
          end
          state_d = DONE;
        end else if (m_q[WIDTH-1]) begin
          state_d = DONE;
        end else if (exp_q == '0) begin
          // Exponent exhausted before the leading one arrived.
          unf_d   = 1'b1;
          state_d = DONE;
        end else begin
          m_d   = m_q << 1;
          exp_d = exp_q - EXP_WIDTH'(1);
        end
      end
      DONE: begin
        if (i_ready) begin
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any item in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_valid     = (state_q == DONE);
  assign o_sign      = sign_q;
  assign o_mant      = m_q[WIDTH-1:0];
  assign o_exp       = exp_q;
  assign o_zero      = zero_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: tb/tb_sign_mag_normalizer.sv
// Randomized scoreboard bench for sign_mag_normalizer.
module tb_sign_mag_normalizer;

  localparam int W  = 23;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          i_rst, i_valid, i_ready;
  logic          i_sign1, i_sign2, i_carry;
  logic [W-1:0]  i_sum;
  logic [EW-1:0] i_exp;
  logic          o_ready, o_valid, o_sign, o_zero, o_overflow, o_underflow;
  logic [W-1:0]  o_mant;
  logic [EW-1:0] o_exp;

  sign_mag_normalizer #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign1(i_sign1), .i_sign2(i_sign2), .i_sum(i_sum), .i_carry(i_carry),
    .i_exp(i_exp), .o_valid(o_valid), .i_ready(i_ready), .o_sign(o_sign),
    .o_mant(o_mant), .o_exp(o_exp), .o_zero(o_zero),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sign;
    int unsigned mant;
    int unsigned exp;
    bit          z, o, u;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   cyc    = 0;
  bit   bp     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    ntests++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain arithmetic on the value, leading-one position by log2.
  function automatic exp_t model(bit s1, bit s2, int unsigned sum, bit c, int unsigned e);
    exp_t r;
    int unsigned mag;
    int unsigned full = 32'd1 << W;
    int p, k;
    r = '{default: 0};
    if (s1 == s2) begin r.sign = s1; mag = (int'(c) * full) + sum; end
    else if (c)   begin r.sign = 0;  mag = sum; end
    else          begin r.sign = 1;  mag = (full - sum) % full; end
    if (mag == 0) r.sign = 0;
    if (mag == 0) begin
      r.z = 1; r.mant = 0; r.exp = 0; r.lat = 2;
    end else if (mag >= full) begin
      r.exp = (e + 1) % 256;
      r.mant = mag / 2;
      if (r.exp == 255) begin r.o = 1; r.mant = 0; end
      r.lat = 2;
    end else begin
      p = $clog2(mag + 1) - 1;
      k = W - 1 - p;
      if (k <= int'(e)) begin
        r.mant = mag << k; r.exp = e - k; r.lat = k + 2;
      end else begin
        r.mant = mag << e; r.exp = 0; r.u = 1; r.lat = int'(e) + 2;
      end
    end
    return r;
  endfunction

  // Holds i_valid from the start; the item must only be taken in IDLE.
  task automatic send(bit s1, bit s2, int unsigned sum, bit c, int unsigned e, bit expect_out);
    exp_t r;
    int t;
    @(negedge clk);
    i_sign1 = s1; i_sign2 = s2; i_sum = W'(sum); i_carry = c; i_exp = EW'(e);
    i_valid = 1'b1;
    t = 0;
    while (!o_ready && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) begin
      chk("accept_timeout", 0, 1);
      i_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (expect_out) begin
      r = model(s1, s2, sum, c, e);
      r.acc = cyc;
      q.push_back(r);
    end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 1000) begin @(negedge clk); t++; end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  // Downstream ready: random, or forced low for backpressure tests.
  initial begin
    i_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      i_ready = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency on first o_valid, stability while stalled, payload on transfer.
  bit seen = 0, have_prev = 0, chk_idle = 0;
  logic [W+EW+3:0] prev;
  always @(negedge clk) begin
    if (i_rst) begin
      seen = 0; have_prev = 0; chk_idle = 0;
    end else if (o_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", o_valid, 0);
      end else begin
        if (!seen) begin
          seen = 1;
          chk("latency", cyc - q[0].acc + 1, q[0].lat);
        end
        if (have_prev)
          chk("hold_stable", {o_sign, o_mant, o_exp, o_zero, o_overflow, o_underflow}, prev);
        chk("ready_low_in_done", o_ready, 0);
        if (i_ready) begin
          chk("sign", o_sign, q[0].sign);
          chk("mant", o_mant, q[0].mant);
          chk("exp", o_exp, q[0].exp);
          chk("zero", o_zero, q[0].z);
          chk("overflow", o_overflow, q[0].o);
          chk("underflow", o_underflow, q[0].u);
          void'(q.pop_front());
          seen = 0; have_prev = 0; chk_idle = 1;
        end else begin
          prev = {o_sign, o_mant, o_exp, o_zero, o_overflow, o_underflow};
          have_prev = 1;
        end
      end
    end else if (chk_idle) begin
      chk("ready_after_transfer", o_ready, 1);
      chk_idle = 0;
    end
  end

  task automatic chk_reset_vals(string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_ready"}, o_ready, 1);
    chk({tag, "_outs"}, {o_sign, o_mant, o_exp, o_zero, o_overflow, o_underflow}, 0);
  endtask

  initial begin
    int unsigned sum, e;
    int t;
    i_rst = 1'b1; i_valid = 1'b0; i_sign1 = 0; i_sign2 = 0;
    i_sum = '0; i_carry = 0; i_exp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    chk_reset_vals("reset");

    // Directed cases.
    send(1, 1, 32'h000001, 1, 32'h80, 1);
    send(0, 1, 32'h7FFFFF, 0, 32'h80, 1);
    send(0, 1, 32'h000000, 1, 32'h40, 1);
    send(1, 1, 32'h000000, 1, 32'hFE, 1);
    send(1, 0, 32'h000100, 1, 32'h05, 1);
    send(0, 0, 32'h400000, 0, 32'h00, 1);
    send(0, 0, 32'h000001, 0, 32'h16, 1);
    drain();

    // Directed backpressure: hold DONE for 5 cycles.
    bp = 1;
    send(1, 1, 32'h000001, 1, 32'h80, 1);
    t = 0;
    while (!o_valid && t < 50) begin @(negedge clk); t++; end
    chk("bp_reached_done", o_valid, 1);
    repeat (5) @(negedge clk);
    bp = 0;
    drain();

    // Randomized stream with mixed leading-one positions and exponents.
    for (int n = 0; n < 80; n++) begin
      sum = $urandom_range(0, (1 << W) - 1) >> $urandom_range(0, W);
      case ($urandom_range(0, 3))
        0:       e = $urandom_range(0, 8);
        1:       e = $urandom_range(250, 255);
        default: e = $urandom_range(0, 255);
      endcase
      send($urandom_range(0, 1), $urandom_range(0, 1), sum, $urandom_range(0, 1), e, 1);
    end
    drain();

    // Reset in the middle of a long normalization drops the item.
    send(0, 1, 32'h7FFFFF, 0, 32'h80, 0);
    repeat (5) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    chk_reset_vals("midnorm_reset");
    repeat (30) @(negedge clk);
    chk("no_valid_after_abort", o_valid, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
